program_loader: RTL and testbench

Fills the 16x8 program RAM before execution, so the controller can fetch from a known image. Accepts bytes over a valid/ready stream, writes them to consecutive RAM addresses from 0, and optionally zero-fills the unused addresses. It then releases the CPU by driving o_program_mode to 1 (execution mode). While loading, it holds o_program_mode at 0 (program mode), which keeps the controller's halt flag raised.

---
 rtl/sap1_pkg.sv | 22 ++
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 style machine: RAM geometry, the
// program/execution mode encoding seen by the controller, and the
// program loader state encoding.
package sap1_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

  // o_program_mode encoding: 0 keeps the CPU halted, 1 lets it run.
  localparam logic PROGRAM_MODE = 1'b0;
  localparam logic EXEC_MODE    = 1'b1;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_CLEAR,
    LD_DONE
  } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Program loader: takes an image over a valid/ready byte stream, writes it
// to consecutive RAM addresses starting at 0, optionally zero-fills the
// remaining addresses, then releases the CPU into execution mode.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_start                   one-cycle request to begin a load (IDLE/DONE)
//   i_data, i_valid, i_last   byte stream in; i_last marks the final byte
//   o_ready                   a byte is accepted this cycle if i_valid
//   o_ram_addr/data/write     RAM write port, one word per strobe cycle
//   o_program_mode            PROGRAM_MODE while loading, EXEC_MODE when done
//   o_busy, o_done            load in progress / image loaded
//   o_overflow                image ran past the last address without i_last
module program_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH = RAM_DATA_W,
  parameter bit CLEAR_REST = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_write,
  output logic                  o_program_mode,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  last_q,  last_d;
  logic                  ovf_q,   ovf_d;
  logic                  ready_q, ready_d;
  logic                  write_q, write_d;
  logic                  pmode_q, pmode_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      LD_IDLE, LD_DONE: begin
        if (i_start) begin
          state_d = LD_RECV;
          addr_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      LD_RECV: begin
        if (i_valid && ready_q) begin
          data_d  = i_data;
          last_d  = i_last;
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (last_q) begin
          if (CLEAR_REST && (addr_q != LAST_ADDR)) begin
            state_d = LD_CLEAR;
            addr_d  = addr_q + 1'b1;
            data_d  = '0;
          end else begin
            state_d = LD_DONE;
          end
        end else if (addr_q == LAST_ADDR) begin
          // Image filled the RAM without a final byte: stop rather than wrap.
          state_d = LD_DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = LD_RECV;
          addr_d  = addr_q + 1'b1;
        end
      end
      LD_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = LD_DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they only
    // ever depend on state and never combinationally on the inputs.
    ready_d = (state_d == LD_RECV);
    write_d = (state_d == LD_WRITE) || (state_d == LD_CLEAR);
    busy_d  = (state_d == LD_RECV) || (state_d == LD_WRITE) || (state_d == LD_CLEAR);
    done_d  = (state_d == LD_DONE);
    pmode_d = (state_d == LD_DONE) ? EXEC_MODE : PROGRAM_MODE;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      pmode_q <= PROGRAM_MODE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      write_q <= write_d;
      pmode_q <= pmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_ram_addr     = addr_q;
  assign o_ram_data     = data_q;
  assign o_ram_write    = write_q;
  assign o_program_mode = pmode_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Two instances share one stimulus
// stream: dut0 with CLEAR_REST=0 and dut1 with CLEAR_REST=1. Each has a
// behavioural RAM that records writes and counts strobes.
module tb_program_loader;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_start;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;

  logic       ready0, wr0, pm0, busy0, done0, ovf0;
  logic [3:0] addr0;
  logic [7:0] data0;
  logic       ready1, wr1, pm1, busy1, done1, ovf1;
  logic [3:0] addr1;
  logic [7:0] data1;

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CLEAR_REST(1'b0)) dut0 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(ready0), .o_ram_addr(addr0), .o_ram_data(data0),
    .o_ram_write(wr0), .o_program_mode(pm0), .o_busy(busy0),
    .o_done(done0), .o_overflow(ovf0)
  );

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CLEAR_REST(1'b1)) dut1 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(ready1), .o_ram_addr(addr1), .o_ram_data(data1),
    .o_ram_write(wr1), .o_program_mode(pm1), .o_busy(busy1),
    .o_done(done1), .o_overflow(ovf1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // RAM models; a preload request fills them and clears the strobe counts.
  logic [7:0] ram0 [16];
  logic [7:0] ram1 [16];
  int         wcnt0 = 0;
  int         wcnt1 = 0;
  logic       pre_req = 1'b0;
  logic [7:0] pre_v0  = 8'h00;
  logic [7:0] pre_v1  = 8'h00;
  int         viol    = 0;

  always @(posedge i_clk) begin
    if (pre_req) begin
      for (int i = 0; i < 16; i++) begin
        ram0[i] <= pre_v0;
        ram1[i] <= pre_v1;
      end
      wcnt0 <= 0;
      wcnt1 <= 0;
    end else begin
      if (wr0) begin
        ram0[addr0] <= data0;
        wcnt0       <= wcnt0 + 1;
      end
      if (wr1) begin
        ram1[addr1] <= data1;
        wcnt1       <= wcnt1 + 1;
      end
    end
  end

  always @(negedge i_clk) begin
    if ((wr0 && ready0) || (wr1 && ready1)) viol <= viol + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v0, input logic [7:0] v1);
    pre_v0  = v0;
    pre_v1  = v1;
    pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
  endtask

  task automatic start_load();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Present a byte, wait (bounded) for dut0 to be ready, complete the
  // transfer edge. Returns at +1 after the transfer edge (WRITE state).
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    i_data  = d;
    i_last  = l;
    i_valid = 1'b1;
    while (!ready0 && n < 20) begin
      tick();
      n++;
    end
    if (!ready0) check("ready_timeout", {31'd0, ready0}, 32'd1);
    tick();
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_last  = 1'b0;
  endtask

  task automatic wait_done1();
    int n = 0;
    while (!done1 && n < 40) begin
      tick();
      n++;
    end
    check("done1_timeout", {31'd0, done1}, 32'd1);
  endtask

  logic [7:0] img [4];
  logic       seen_ready;

  initial begin
    img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'hE0; img[3] = 8'hF0;
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_data    = 8'h00;
    i_valid   = 1'b0;
    i_last    = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_ready", {31'd0, ready1}, 32'd0);
    check("rst_write", {31'd0, wr1},    32'd0);
    check("rst_pmode", {31'd0, pm1},    32'd0);
    check("rst_busy",  {31'd0, busy1},  32'd0);
    check("rst_done",  {31'd0, done1},  32'd0);
    check("rst_ovf",   {31'd0, ovf1},   32'd0);
    check("rst_addr",  {28'd0, addr1},  32'd0);
    check("rst_data",  {24'd0, data1},  32'd0);

    // Four-byte image, last on 0xF0
    preload(8'hAA, 8'h55);
    start_load();
    check("start_busy", {31'd0, busy0}, 32'd1);
    for (int i = 0; i < 4; i++) send_byte(img[i], (i == 3));
    check("w4_strobe0", {31'd0, wr0},   32'd1);
    check("w4_done0",   {31'd0, done0}, 32'd0);
    tick();
    check("done0_next", {31'd0, done0}, 32'd1);
    check("pmode0",     {31'd0, pm0},   32'd1);
    check("busy1_clr",  {31'd0, busy1}, 32'd1);
    wait_done1();
    check("pmode1", {31'd0, pm1},  32'd1);
    check("ovf0",   {31'd0, ovf0}, 32'd0);
    check("ovf1",   {31'd0, ovf1}, 32'd0);
    check("wcnt0",  wcnt0, 32'd4);
    check("wcnt1",  wcnt1, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("img0_ram[%0d]", i), {24'd0, ram0[i]}, (i < 4) ? {24'd0, img[i]} : 32'hAA);
      check($sformatf("img1_ram[%0d]", i), {24'd0, ram1[i]}, (i < 4) ? {24'd0, img[i]} : 32'h00);
    end

    // Overflow: 16 bytes without i_last, then a 17th that must be refused
    preload(8'h00, 8'h00);
    start_load();
    check("restart_pmode", {31'd0, pm0},   32'd0);
    check("restart_done",  {31'd0, done0}, 32'd0);
    check("restart_addr",  {28'd0, addr0}, 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b0);
    check("ovf_last_addr", {28'd0, addr0}, 32'd15);
    tick();
    check("ovf_flag0", {31'd0, ovf0},  32'd1);
    check("ovf_flag1", {31'd0, ovf1},  32'd1);
    check("ovf_done0", {31'd0, done0}, 32'd1);
    check("ovf_done1", {31'd0, done1}, 32'd1);
    i_data     = 8'h99;
    i_valid    = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen_ready = seen_ready | ready0 | ready1;
      tick();
    end
    i_valid = 1'b0;
    check("ovf_no_ready", {31'd0, seen_ready}, 32'd0);
    check("ovf_wcnt0", wcnt0, 32'd16);
    check("ovf_wcnt1", wcnt1, 32'd16);
    for (int i = 0; i < 16; i += 5)
      check($sformatf("ovf_ram[%0d]", i), {24'd0, ram1[i]}, 32'h30 + 32'(i));
    check("ovf_ram[15]", {24'd0, ram0[15]}, 32'h3F);

    // Stalls, plus i_start while in RECV
    preload(8'hCC, 8'hCC);
    start_load();
    check("stall_ovf_clr", {31'd0, ovf0}, 32'd0);
    tick();
    tick();
    send_byte(8'h11, 1'b0);
    tick();
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("recv_start_addr",  {28'd0, addr0},  32'd1);
    check("recv_start_ready", {31'd0, ready0}, 32'd1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    wait_done1();
    check("stall_done0", {31'd0, done0}, 32'd1);
    check("stall_wcnt0", wcnt0, 32'd3);
    check("stall_wcnt1", wcnt1, 32'd16);
    check("stall_ram0[0]", {24'd0, ram0[0]}, 32'h11);
    check("stall_ram0[1]", {24'd0, ram0[1]}, 32'h22);
    check("stall_ram0[2]", {24'd0, ram0[2]}, 32'h33);
    check("stall_ram0[3]", {24'd0, ram0[3]}, 32'hCC);
    check("stall_ram1[3]", {24'd0, ram1[3]}, 32'h00);

    // Reset asserted during CLEAR at address 7
    preload(8'h00, 8'h00);
    start_load();
    send_byte(8'h5A, 1'b1);
    begin
      int n = 0;
      while (!(wr1 && addr1 == 4'd7) && n < 30) begin
        tick();
        n++;
      end
    end
    check("clr_addr7", {28'd0, addr1}, 32'd7);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_write", {31'd0, wr1},    32'd0);
    check("arst_ready", {31'd0, ready1}, 32'd0);
    check("arst_pmode", {31'd0, pm1},    32'd0);
    check("arst_busy",  {31'd0, busy1},  32'd0);
    check("arst_wcnt1", wcnt1, 32'd7);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();

    // i_start and i_valid together in IDLE: byte must not be consumed
    i_start = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'hEE;
    tick();
    i_start = 1'b0;
    i_valid = 1'b0;
    check("sim_ready", {31'd0, ready1}, 32'd1);
    check("sim_write", {31'd0, wr1},    32'd0);
    send_byte(8'h77, 1'b1);
    check("reload_addr", {28'd0, addr1}, 32'd0);
    check("reload_data", {24'd0, data1}, 32'h77);
    wait_done1();
    check("reload_ram1[0]", {24'd0, ram1[0]}, 32'h77);
    check("no_write_while_ready", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
